iob_debounce: RTL and testbench

Single-bit debouncer and edge detector. It sits directly downstream of the two-flop synchronizer and consumes its already-synchronized output. It suppresses glitches shorter than a programmable number of enabled cycles and emits a clean level plus one-cycle rise and fall strobes for control logic. All logic runs in one clock domain.

---
 rtl/iob_debounce.sv | 120 ++++++++++++
 tb/tb_iob_debounce.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/iob_debounce.sv
// iob_debounce: single-bit debouncer with registered level and one-cycle rise/fall strobes.
// Revision: 1.0
`default_nettype none

module iob_debounce #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic en_i,
  input  logic signal_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // state[1] is the debounced level, state[0] marks a qualification in progress
  localparam logic [1:0] STABLE_LO = 2'b00;
  localparam logic [1:0] WAIT_HI   = 2'b01;
  localparam logic [1:0] STABLE_HI = 2'b10;
  localparam logic [1:0] WAIT_LO   = 2'b11;

  localparam logic [1:0]       RST_STATE = RST_VAL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             rise;
  logic             fall;
  logic             next_rise;
  logic             next_fall;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= RST_STATE;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      rise  <= next_rise;
      fall  <= next_fall;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_rise  = 1'b0;
    next_fall  = 1'b0;
    if (en_i) begin
      case (state)
        STABLE_LO: begin
          if (signal_i) begin
            if (DEBOUNCE_CYCLES == 1) begin
              next_state = STABLE_HI;
              next_rise  = 1'b1;
            end else begin
              next_state = WAIT_HI;
              next_cnt   = CNT_ONE;
            end
          end
        end
        WAIT_HI: begin
          if (!signal_i) begin
            next_state = STABLE_LO;
            next_cnt   = '0;
          end else if (cnt == CNT_LAST) begin
            next_state = STABLE_HI;
            next_rise  = 1'b1;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!signal_i) begin
            if (DEBOUNCE_CYCLES == 1) begin
              next_state = STABLE_LO;
              next_fall  = 1'b1;
            end else begin
              next_state = WAIT_LO;
              next_cnt   = CNT_ONE;
            end
          end
        end
        default: begin
          if (signal_i) begin
            next_state = STABLE_HI;
            next_cnt   = '0;
          end else if (cnt == CNT_LAST) begin
            next_state = STABLE_LO;
            next_fall  = 1'b1;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    level_o = state[1];
    busy_o  = state[0];
    rise_o  = rise;
    fall_o  = fall;
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_debounce.sv
// tb_iob_debounce: three configurations (4/0, 1/1, 8/0) checked against a run-length model every cycle.
// Revision: 1.0
`default_nettype none

module tb_iob_debounce;

  logic       clk = 1'b0;
  logic [2:0] rstn;
  logic [2:0] en;
  logic [2:0] sig;
  wire  [2:0] lvl;
  wire  [2:0] rise;
  wire  [2:0] fall;
  wire  [2:0] busy;

  int dc[3] = '{4, 1, 8};
  bit rv[3] = '{1'b0, 1'b1, 1'b0};

  int m_run[3];
  bit m_lvl[3];
  bit m_rise[3];
  bit m_fall[3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iob_debounce #(.DEBOUNCE_CYCLES(4), .RST_VAL(1'b0)) u_d0 (
    .clk_i(clk), .arst_n_i(rstn[0]), .en_i(en[0]), .signal_i(sig[0]),
    .level_o(lvl[0]), .rise_o(rise[0]), .fall_o(fall[0]), .busy_o(busy[0]));
  iob_debounce #(.DEBOUNCE_CYCLES(1), .RST_VAL(1'b1)) u_d1 (
    .clk_i(clk), .arst_n_i(rstn[1]), .en_i(en[1]), .signal_i(sig[1]),
    .level_o(lvl[1]), .rise_o(rise[1]), .fall_o(fall[1]), .busy_o(busy[1]));
  iob_debounce #(.DEBOUNCE_CYCLES(8), .RST_VAL(1'b0)) u_d2 (
    .clk_i(clk), .arst_n_i(rstn[2]), .en_i(en[2]), .signal_i(sig[2]),
    .level_o(lvl[2]), .rise_o(rise[2]), .fall_o(fall[2]), .busy_o(busy[2]));

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Model: level flips once DEBOUNCE_CYCLES consecutive enabled samples disagree with it
  always @(rstn) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstn[i]) begin
        m_run[i] = 0; m_lvl[i] = rv[i]; m_rise[i] = 0; m_fall[i] = 0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstn[i]) begin
        m_run[i] = 0; m_lvl[i] = rv[i]; m_rise[i] = 0; m_fall[i] = 0;
      end else begin
        m_rise[i] = 0;
        m_fall[i] = 0;
        if (en[i]) begin
          if (sig[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == dc[i]) begin
              m_lvl[i]  = sig[i];
              m_rise[i] = sig[i];
              m_fall[i] = !sig[i];
              m_run[i]  = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_level%0d", i), lvl[i],  m_lvl[i]);
      chk($sformatf("model_rise%0d", i),  rise[i], m_rise[i]);
      chk($sformatf("model_fall%0d", i),  fall[i], m_fall[i]);
      chk($sformatf("model_busy%0d", i),  busy[i], m_run[i] > 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst(input int i);
    rstn[i] = 1'b0;
    tick();
    rstn[i] = 1'b1;
  endtask

  initial begin
    logic pat[7];
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rstn = 3'b000;
    en   = 3'b001;
    sig  = 3'b011;

    // Reset with input high: nothing may propagate
    tick(); tick();
    chk("rst_level", lvl[0], 1'b0);
    chk("rst_busy",  busy[0], 1'b0);
    chk("rst_rise",  rise[0], 1'b0);
    chk("rst_level1", lvl[1], 1'b1);
    rstn = 3'b111;
    tick();
    chk("first_busy", busy[0], 1'b1);
    tick(); tick();
    chk("third_level", lvl[0], 1'b0);
    tick();
    chk("fourth_level", lvl[0], 1'b1);
    chk("fourth_rise",  rise[0], 1'b1);
    tick();
    chk("rise_width", rise[0], 1'b0);

    // Three-sample glitch rejected, four-sample run accepted
    pulse_rst(0);
    sig[0] = 1'b0;
    tick();
    sig[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("glitch_busy", busy[0], 1'b1);
      chk("glitch_level", lvl[0], 1'b0);
    end
    sig[0] = 1'b0;
    tick();
    chk("glitch_end_busy", busy[0], 1'b0);
    chk("glitch_no_rise", rise[0], 1'b0);
    sig[0] = 1'b1;
    tick(); tick(); tick(); tick();
    chk("run4_rise", rise[0], 1'b1);
    chk("run4_level", lvl[0], 1'b1);

    // Enable gating: rises on the fourth enabled edge only
    pulse_rst(0);
    sig[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      en[0] = pat[k];
      tick();
      chk("gate_level", lvl[0], (k == 6) ? 1'b1 : 1'b0);
    end
    chk("gate_rise", rise[0], 1'b1);
    en[0] = 1'b0;
    tick();
    chk("gate_rise_clear", rise[0], 1'b0);
    chk("gate_level_hold", lvl[0], 1'b1);

    // Single-cycle debounce with high reset value
    sig[1] = 1'b0;
    en[1]  = 1'b1;
    tick();
    chk("d1_level", lvl[1], 1'b0);
    chk("d1_fall",  fall[1], 1'b1);
    chk("d1_busy",  busy[1], 1'b0);
    sig[1] = 1'b1;
    tick();
    chk("d1_rise",  rise[1], 1'b1);
    chk("d1_fall_clear", fall[1], 1'b0);
    tick();
    chk("d1_rise_clear", rise[1], 1'b0);

    // Asynchronous reset in the middle of an 8-cycle qualification
    en[2]  = 1'b1;
    sig[2] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("d8_busy_mid", busy[2], 1'b1);
    #2 rstn[2] = 1'b0;
    #1;
    chk("d8_async_busy", busy[2], 1'b0);
    chk("d8_async_level", lvl[2], 1'b0);
    tick();
    rstn[2] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("d8_no_early_rise", rise[2], 1'b0);
    end
    tick();
    chk("d8_rise", rise[2], 1'b1);
    chk("d8_level", lvl[2], 1'b1);

    // Randomized traffic, checked by the per-cycle compare process
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) begin
        en[i] = ($urandom_range(3) != 0);
        if ($urandom_range(5) == 0) sig[i] = ~sig[i];
        rstn[i] = ($urandom_range(499) != 0);
      end
      tick();
    end
    rstn = 3'b111;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
